pwm_multi_channel: RTL and testbench
====================================

// Module: pwm_multi_channel
// PURPOSE
// - Parametrised successor to the onboarding PWM peripheral: NUM_CH independent PWM channels sharing one period counter.
// - Adds programmable period (TOP), a clock prescaler, and edge- or center-aligned mode.
// - Duty/period/mode go through shadow registers with glitch-free update at the period boundary.
// - Sits behind the SPI register peripheral (write/read port below); drives uo_out/uio_out in the top.
// PARAMETERS
// - NUM_CH   8  number of PWM channels (1..CNT_W)
// - CNT_W    8  counter, duty and period width; also register data width
// - PRESC_W  4  prescaler field width
// - ADDR_W   7  register address width (must cover 4+NUM_CH entries)
// PORTS
// - clk           in   1        system clock
// - rst           in   1        asynchronous reset, active-high
// - wr_en         in   1        register write strobe, one clk per write
// - wr_addr       in   ADDR_W   write address
// - wr_data       in   CNT_W    write data
// - rd_addr       in   ADDR_W   readback address
// - rd_data       out  CNT_W    readback data, combinational from rd_addr (shadow/ctrl values)
// - pwm_out       out  NUM_CH   channel outputs, registered
// - period_start  out  1        one-clk pulse when the counter (re)enters 0 on a tick, registered
// BEHAVIOUR
// - Register map (unused bits read 0; unmapped addr: write ignored, read 0):
//     0 OUT_EN[NUM_CH-1:0]; 1 PWM_EN[NUM_CH-1:0]; 2 CTRL {bit PRESC_W = MODE (0 edge, 1 center), [PRESC_W-1:0] = PRESC};
//     3 PERIOD (TOP); 4+i DUTY[i].
// - Reset values: OUT_EN=0, PWM_EN=0, CTRL=0, PERIOD=all ones, DUTY=0, counter=0, direction=up.
//   Active copies take the same values. pwm_out=0, period_start=0. Reset clears all state asynchronously, mid-period included.
// - Timing domains:
//     OUT_EN, PWM_EN, PRESC apply the clk after the write; a PRESC write also clears the prescaler count.
//     DUTY, PERIOD, MODE write shadow regs only; copied to active at the next boundary.
// - Prescaler: tick asserted once every PRESC+1 clks (PRESC=0 -> every clk). Counter moves only on tick.
// - Edge mode:
//     cnt 0,1..TOP, then 0. Boundary = tick where cnt goes TOP->0.
//     Period = (TOP+1)*(PRESC+1) clk.
// - Center mode:
//     cnt counts up 0..TOP, then down TOP-1..1, then 0. Boundary = tick where cnt goes 1->0.
//     Period = 2*TOP*(PRESC+1) clk.
//     MODE change takes effect at a boundary; the counter restarts at 0 counting up.
// - TOP=0 (either mode): cnt held at 0; every tick is a boundary.
// - Channel i compare, registered:
//     pwm_out[i] <= OUT_EN[i] & (~PWM_EN[i] | (cnt < duty_act[i])).
//     So DUTY=0 -> always low. DUTY>TOP -> always high. PWM_EN=0 with OUT_EN=1 -> static high.
//     pwm_out lags the counter by 1 clk.
// - Boundary load: active <= shadow as held before this clk. A write landing on the boundary clk updates shadow only
//   and takes effect at the following boundary.
// - period_start is asserted the clk the new period's first compare appears on pwm_out, so it is aligned with pwm_out.
//   After reset the first boundary is cnt TOP->0 (or 1->0); there is no pulse at reset release.
// - Unsigned arithmetic throughout, CNT_W bits. Counter wrap never overflows: compares run before increment.
// TESTING
// - Reset: assert rst mid-run -> pwm_out=0, period_start=0 same cycle; read addr 3 -> 0xFF, addr 4 -> 0x00.
// - Edge, TOP=9, PRESC=0, DUTY0=3, OUT_EN=PWM_EN=0x01 -> ch0 high 3 clk of every 10; period_start every 10 clk,
//   coincident with the rising edge.
// - Extremes: DUTY0=0 -> constant 0; DUTY0=10 -> constant 1; PWM_EN=0, OUT_EN=1 -> constant 1;
//   OUT_EN=0 -> 0 regardless; unmapped addr 0x7F write -> no change, read 0.
// - Shadow: DUTY0 3->7 written mid-period -> current period stays 3 high; next period after period_start is 7 high.
//   A write exactly on the boundary clk -> applied one period later.
// - Center, TOP=4, DUTY0=2 -> 8-clk period, cnt 0,1,2,3,4,3,2,1; ch0 high 3 clk, symmetric about cnt=0.
// - Prescaler: PRESC=3, TOP=9, edge, DUTY0=5 -> period 40 clk, high 20 clk.
//   Change PRESC mid-run -> new tick spacing from the next clk.

Source files
------------

// File: rtl/pwm_multi_channel.sv
// NUM_CH PWM channels sharing one prescaled period counter (edge or center aligned).
// Duty, period and mode are double-buffered and swap in at the period boundary.
module pwm_multi_channel #(
  parameter int NUM_CH  = 8,
  parameter int CNT_W   = 8,
  parameter int PRESC_W = 4,
  parameter int ADDR_W  = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [CNT_W-1:0]  wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [CNT_W-1:0]  rd_data,
  output logic [NUM_CH-1:0] pwm_out,
  output logic              period_start
);

  localparam logic [ADDR_W-1:0] ADDR_OUT_EN = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] ADDR_PWM_EN = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_CTRL   = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] ADDR_PERIOD = ADDR_W'(3);
  localparam int                DUTY_BASE   = 4;

  logic [NUM_CH-1:0]  out_en_reg;
  logic [NUM_CH-1:0]  pwm_en_reg;
  logic [PRESC_W-1:0] presc_reg;
  logic [PRESC_W-1:0] presc_cnt_reg;
  logic               mode_sh_reg;
  logic               mode_act_reg;
  logic [CNT_W-1:0]   period_sh_reg;
  logic [CNT_W-1:0]   period_act_reg;
  logic [CNT_W-1:0]   duty_sh_reg  [NUM_CH];
  logic [CNT_W-1:0]   duty_act_reg [NUM_CH];
  logic [CNT_W-1:0]   cnt_reg;
  logic [CNT_W-1:0]   cnt_next;
  logic               dir_down_reg;
  logic               dir_down_next;
  logic               boundary_reg;
  logic               tick;
  logic               boundary;
  logic [NUM_CH-1:0]  pwm_next;

  logic              wr_out_en;
  logic              wr_pwm_en;
  logic              wr_ctrl;
  logic              wr_period;
  logic [NUM_CH-1:0] wr_duty;

  assign wr_out_en = wr_en && (wr_addr == ADDR_OUT_EN);
  assign wr_pwm_en = wr_en && (wr_addr == ADDR_PWM_EN);
  assign wr_ctrl   = wr_en && (wr_addr == ADDR_CTRL);
  assign wr_period = wr_en && (wr_addr == ADDR_PERIOD);

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_duty_dec
      assign wr_duty[gi] = wr_en && (wr_addr == ADDR_W'(DUTY_BASE + gi));
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_en_reg    <= '0;
      pwm_en_reg    <= '0;
      presc_reg     <= '0;
      mode_sh_reg   <= 1'b0;
      period_sh_reg <= '1;
    end else begin
      if (wr_out_en) out_en_reg <= wr_data[NUM_CH-1:0];
      if (wr_pwm_en) pwm_en_reg <= wr_data[NUM_CH-1:0];
      if (wr_ctrl) begin
        presc_reg   <= wr_data[PRESC_W-1:0];
        mode_sh_reg <= wr_data[PRESC_W];
      end
      if (wr_period) period_sh_reg <= wr_data;
    end
  end

  // A CTRL write restarts the prescaler so the new spacing counts from the write.
  assign tick = (presc_cnt_reg == presc_reg);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_cnt_reg <= '0;
    end else if (wr_ctrl || tick) begin
      presc_cnt_reg <= '0;
    end else begin
      presc_cnt_reg <= presc_cnt_reg + 1'b1;
    end
  end

  always_comb begin
    cnt_next      = cnt_reg;
    dir_down_next = dir_down_reg;
    if (!mode_act_reg) begin
      if (cnt_reg == period_act_reg) cnt_next = '0;
      else                           cnt_next = cnt_reg + 1'b1;
    end else if (dir_down_reg) begin
      cnt_next = cnt_reg - 1'b1;
    end else if (cnt_reg == period_act_reg) begin
      // TOP of 0 or 1 has no down leg: the peak falls straight back to 0.
      if (period_act_reg <= CNT_W'(1)) begin
        cnt_next = '0;
      end else begin
        cnt_next      = period_act_reg - 1'b1;
        dir_down_next = 1'b1;
      end
    end else begin
      cnt_next = cnt_reg + 1'b1;
    end
  end

  assign boundary = tick && (cnt_next == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg        <= '0;
      dir_down_reg   <= 1'b0;
      mode_act_reg   <= 1'b0;
      period_act_reg <= '1;
      boundary_reg   <= 1'b0;
      period_start   <= 1'b0;
    end else begin
      boundary_reg <= boundary;
      period_start <= boundary_reg;
      if (tick) begin
        cnt_reg      <= cnt_next;
        dir_down_reg <= boundary ? 1'b0 : dir_down_next;
      end
      if (boundary) begin
        mode_act_reg   <= mode_sh_reg;
        period_act_reg <= period_sh_reg;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        duty_sh_reg[i]  <= '0;
        duty_act_reg[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (wr_duty[i]) duty_sh_reg[i]  <= wr_data;
        if (boundary)   duty_act_reg[i] <= duty_sh_reg[i];
      end
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_cmp
      assign pwm_next[gi] = out_en_reg[gi] &
                            (~pwm_en_reg[gi] | (cnt_reg < duty_act_reg[gi]));
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pwm_out <= '0;
    else     pwm_out <= pwm_next;
  end

  always_comb begin
    rd_data = '0;
    case (rd_addr)
      ADDR_OUT_EN: rd_data[NUM_CH-1:0] = out_en_reg;
      ADDR_PWM_EN: rd_data[NUM_CH-1:0] = pwm_en_reg;
      ADDR_CTRL:   rd_data[PRESC_W:0]  = {mode_sh_reg, presc_reg};
      ADDR_PERIOD: rd_data             = period_sh_reg;
      default:     ;
    endcase
    for (int i = 0; i < NUM_CH; i++) begin
      if (rd_addr == ADDR_W'(DUTY_BASE + i)) rd_data = duty_sh_reg[i];
    end
  end

endmodule

// File: tb/tb_pwm_multi_channel.sv
// Directed and randomized bench for pwm_multi_channel with a period-position reference model.
module tb_pwm_multi_channel;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_en = 1'b0;
  logic [6:0] wr_addr = '0;
  logic [7:0] wr_data = '0;
  logic [6:0] rd_addr = 7'd3;
  logic [7:0] rd_data;
  logic [7:0] pwm_out;
  logic       period_start;

  int checks = 0;
  int errors = 0;

  pwm_multi_channel #(.NUM_CH(8), .CNT_W(8), .PRESC_W(4), .ADDR_W(7)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data), .pwm_out(pwm_out), .period_start(period_start)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL global_timeout checks %0d errors %0d", checks, errors);
    $fatal(1, "simulation time limit reached");
  end

  // Reference model: position in the period counted in ticks, count derived arithmetically.
  logic [7:0] m_out_en, m_pwm_en;
  int         m_presc, m_ref, m_n, m_k;
  bit         m_mode_sh, m_mode_act, m_bnd_prev;
  int         m_top_sh, m_top_act;
  int         m_duty_sh [8];
  int         m_duty_act[8];
  logic [7:0] exp_pwm;
  logic       exp_ps;

  function automatic int cnt_of(int k, int top, bit mode);
    if (!mode || k <= top) return k;
    return 2 * top - k;
  endfunction

  function automatic int ticks_pp(int top, bit mode);
    if (!mode) return top + 1;
    return (top == 0) ? 1 : 2 * top;
  endfunction

  function automatic logic [7:0] rd_model(int a);
    if (a == 0) return m_out_en;
    if (a == 1) return m_pwm_en;
    if (a == 2) return {3'b000, m_mode_sh, 4'(m_presc)};
    if (a == 3) return 8'(m_top_sh);
    if (a >= 4 && a < 12) return 8'(m_duty_sh[a-4]);
    return 8'h00;
  endfunction

  task automatic model_reset();
    m_out_en = '0; m_pwm_en = '0; m_presc = 0; m_ref = 0; m_n = 0; m_k = 0;
    m_mode_sh = 0; m_mode_act = 0; m_bnd_prev = 0;
    m_top_sh = 255; m_top_act = 255;
    for (int i = 0; i < 8; i++) begin
      m_duty_sh[i] = 0;
      m_duty_act[i] = 0;
    end
  endtask

  task automatic model_edge();
    bit tick;
    bit bnd;
    int cnt;
    int a;
    m_n++;
    tick = ((m_n - m_ref) % (m_presc + 1)) == 0;
    cnt = cnt_of(m_k, m_top_act, m_mode_act);
    for (int i = 0; i < 8; i++)
      exp_pwm[i] = m_out_en[i] & (~m_pwm_en[i] | (cnt < m_duty_act[i]));
    exp_ps = m_bnd_prev;
    bnd = 0;
    if (tick) begin
      if (m_k + 1 >= ticks_pp(m_top_act, m_mode_act)) begin
        bnd = 1;
        m_k = 0;
        m_mode_act = m_mode_sh;
        m_top_act = m_top_sh;
        for (int i = 0; i < 8; i++) m_duty_act[i] = m_duty_sh[i];
      end else begin
        m_k++;
      end
    end
    m_bnd_prev = bnd;
    if (wr_en) begin
      a = int'(wr_addr);
      if (a == 0) m_out_en = wr_data;
      else if (a == 1) m_pwm_en = wr_data;
      else if (a == 2) begin
        m_presc = int'(wr_data[3:0]);
        m_mode_sh = wr_data[4];
        m_ref = m_n;
      end
      else if (a == 3) m_top_sh = int'(wr_data);
      else if (a >= 4 && a < 12) m_duty_sh[a-4] = int'(wr_data);
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    int r;
    @(posedge clk);
    model_edge();
    #1;
    chk("pwm_out", pwm_out, exp_pwm);
    chk("period_start", period_start, exp_ps);
    chk("rd_data", rd_data, rd_model(int'(rd_addr)));
    r = $urandom_range(0, 16);
    rd_addr = (r == 16) ? 7'h7F : 7'(r);
  endtask

  task automatic do_write(input logic [6:0] a, input logic [7:0] d);
    wr_en = 1'b1;
    wr_addr = a;
    wr_data = d;
    step();
    wr_en = 1'b0;
  endtask

  task automatic check_rd(input string tag, input logic [6:0] a, input logic [7:0] exp);
    rd_addr = a;
    #1;
    chk(tag, rd_data, exp);
  endtask

  // Measures one full period from a period_start pulse; optional write at sample index wr_at.
  task automatic measure(input int ch, input int wr_at, input logic [6:0] a, input logic [7:0] d,
                         output int len, output int highs, output logic [63:0] pat);
    int c;
    c = 0;
    while (period_start !== 1'b1 && c < 2000) begin
      step();
      c++;
    end
    chk("wait_period_start", period_start, 1);
    len = 0;
    highs = 0;
    pat = '0;
    do begin
      if (pwm_out[ch] === 1'b1) begin
        highs++;
        if (len < 64) pat[len] = 1'b1;
      end
      if (len == wr_at) do_write(a, d);
      else step();
      len++;
    end while (period_start !== 1'b1 && len < 2000);
  endtask

  initial begin
    int len, highs;
    logic [63:0] pat;
    int top, d;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_pwm_out", pwm_out, 0);
    chk("reset_period_start", period_start, 0);
    chk("reset_rd_period", rd_data, 8'hFF);
    check_rd("reset_rd_duty0", 7'd4, 8'h00);
    rst = 1'b0;
    model_reset();

    // Edge mode, TOP=9, DUTY0=3
    do_write(7'd3, 8'd9);
    do_write(7'd2, 8'h00);
    do_write(7'd4, 8'd3);
    do_write(7'd0, 8'h01);
    do_write(7'd1, 8'h01);
    for (int p = 0; p < 2; p++) begin
      measure(0, -1, 7'd0, 8'd0, len, highs, pat);
      chk("edge_len", len, 10);
      chk("edge_high", highs, 3);
      chk("edge_pattern", pat[31:0], 32'h7);
    end

    // Extremes
    do_write(7'd4, 8'd0);
    measure(0, -1, 7'd0, 8'd0, len, highs, pat);
    chk("duty0_high", highs, 0);
    do_write(7'd4, 8'd10);
    measure(0, -1, 7'd0, 8'd0, len, highs, pat);
    chk("duty_over_top_high", highs, 10);
    do_write(7'd4, 8'd3);
    do_write(7'd1, 8'h00);
    measure(0, -1, 7'd0, 8'd0, len, highs, pat);
    chk("pwm_en_off_high", highs, 10);
    do_write(7'd0, 8'h00);
    do_write(7'd1, 8'h01);
    measure(0, -1, 7'd0, 8'd0, len, highs, pat);
    chk("out_en_off_high", highs, 0);
    do_write(7'h7F, 8'hAB);
    check_rd("unmapped_rd", 7'h7F, 8'h00);
    check_rd("duty0_after_unmapped", 7'd4, 8'd3);
    check_rd("period_after_unmapped", 7'd3, 8'd9);
    do_write(7'd0, 8'h01);

    // Shadow: mid-period write applies next period, boundary write one period later
    measure(0, 4, 7'd4, 8'd7, len, highs, pat);
    chk("shadow_cur_high", highs, 3);
    measure(0, -1, 7'd0, 8'd0, len, highs, pat);
    chk("shadow_next_high", highs, 7);
    measure(0, 8, 7'd4, 8'd2, len, highs, pat);
    chk("bnd_wr_cur_high", highs, 7);
    measure(0, -1, 7'd0, 8'd0, len, highs, pat);
    chk("bnd_wr_next_high", highs, 7);
    measure(0, -1, 7'd0, 8'd0, len, highs, pat);
    chk("bnd_wr_later_high", highs, 2);

    // Center mode, TOP=4, DUTY0=2
    do_write(7'd2, 8'h10);
    do_write(7'd3, 8'd4);
    do_write(7'd4, 8'd2);
    for (int p = 0; p < 2; p++) begin
      measure(0, -1, 7'd0, 8'd0, len, highs, pat);
      chk("center_len", len, 8);
      chk("center_high", highs, 3);
      chk("center_pattern", pat[31:0], 32'h83);
    end

    // Prescaler, then PRESC change mid-period
    do_write(7'd2, 8'h03);
    do_write(7'd3, 8'd9);
    do_write(7'd4, 8'd5);
    measure(0, -1, 7'd0, 8'd0, len, highs, pat);
    chk("presc_len", len, 40);
    chk("presc_high", highs, 20);
    measure(0, 10, 7'd2, 8'h01, len, highs, pat);
    chk("presc_change_len", len, 26);
    chk("presc_change_high", highs, 16);
    measure(0, -1, 7'd0, 8'd0, len, highs, pat);
    chk("presc1_len", len, 20);
    chk("presc1_high", highs, 10);

    // Randomized configurations and writes, checked every clk against the model
    for (int it = 0; it < 8; it++) begin
      top = $urandom_range(0, 12);
      do_write(7'd3, 8'(top));
      do_write(7'd2, 8'($urandom_range(0, 31)));
      for (int ch = 0; ch < 8; ch++) begin
        if ($urandom_range(0, 1) == 1) do_write(7'(4 + ch), 8'($urandom_range(0, top + 2)));
      end
      do_write(7'd0, 8'($urandom_range(0, 255)));
      do_write(7'd1, 8'($urandom_range(0, 255)));
      repeat ($urandom_range(100, 250)) begin
        if ($urandom_range(0, 9) == 0) begin
          d = $urandom_range(0, 13);
          if (d == 3) do_write(7'd3, 8'($urandom_range(0, 15)));
          else do_write(7'(d), 8'($urandom_range(0, 255)));
        end else begin
          step();
        end
      end
    end

    // Asynchronous reset in the middle of a run
    do_write(7'd0, 8'hFF);
    do_write(7'd1, 8'h00);
    step();
    step();
    chk("static_high_before_reset", pwm_out, 8'hFF);
    #2;
    rst = 1'b1;
    #1;
    chk("async_reset_pwm_out", pwm_out, 0);
    chk("async_reset_period_start", period_start, 0);
    check_rd("async_reset_rd_period", 7'd3, 8'hFF);
    check_rd("async_reset_rd_duty0", 7'd4, 8'h00);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    repeat (300) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
